// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART transmitter: buffers up to DEPTH bytes and launches one
// frame at a time via start_trigger. Define UART_TXQ_FLUSH_EN to add the flush input.
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf,
`ifdef UART_TXQ_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          tx_busy,
    output logic          start_trigger,
    output logic [7:0]    tx_data
);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_nxt;
    logic          push, pop, drop, do_flush;

`ifdef UART_TXQ_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    // flush takes priority over a same-cycle push; a dropped push still flags overflow
    assign push = wr_en && !full && !do_flush;
    assign drop = wr_en && full;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy && !do_flush) begin
                    pop       = 1'b1;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: if (tx_busy)  state_nxt = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_ONE;
        else if (pop && !push)
            count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            overflow      <= 1'b0;
            start_trigger <= 1'b0;
            tx_data       <= 8'h00;
        end else begin
            state         <= state_nxt;
            start_trigger <= pop;
            if (pop)
                tx_data <= mem[rd_ptr];
            if (clr_ovf)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
            if (do_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                full   <= 1'b0;
                empty  <= 1'b1;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                count <= count_nxt;
                full  <= (count_nxt == CNT_FULL);
                empty <= (count_nxt == '0);
            end
        end
    end

    // storage needs no reset; entries are only read after being written
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios plus a randomized run
// checked against a queue-based model of the FIFO and a simple transmitter model.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, clr_ovf, tx_busy;
    logic [7:0]    wr_data;
    logic          full, empty, overflow, start_trigger;
    logic [AW:0]   count;
    logic [7:0]    tx_data;
`ifdef UART_TXQ_FLUSH_EN
    logic          flush;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // transmitter model: busy for a chosen number of cycles after each launch
    bit   tx_auto = 1'b0;
    logic tb_busy = 1'b0;
    logic model_busy = 1'b0;
    int   busy_left = 0;
    int   busy_min = 1, busy_max = 1;
    bit   prev_st = 1'b0;
    int   dbl_pulse = 0;
    logic [7:0] launches[$];
    int   launch_cyc[$];
    int   fall_cyc[$];

    assign tx_busy = tx_auto ? model_busy : tb_busy;

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .clr_ovf(clr_ovf),
`ifdef UART_TXQ_FLUSH_EN
        .flush(flush),
`endif
        .tx_busy(tx_busy), .start_trigger(start_trigger), .tx_data(tx_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!tx_auto) model_busy = 1'b0;
        if (start_trigger) begin
            launches.push_back(tx_data);
            launch_cyc.push_back(cyc);
            if (prev_st) dbl_pulse++;
            if (tx_auto) begin
                model_busy = 1'b1;
                busy_left  = int'($urandom_range(busy_max, busy_min));
            end
        end else if (model_busy) begin
            busy_left--;
            if (busy_left <= 0) begin
                model_busy = 1'b0;
                fall_cyc.push_back(cyc);
            end
        end
        prev_st = start_trigger;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
        tb_busy = 1'b0; tx_auto = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    // manual transmitter handshake: drop busy, wait for a launch, then go busy again
    task automatic handshake();
        int n = launches.size();
        int k = 0;
        tb_busy = 1'b0;
        while (launches.size() == n && k < 20) begin step(); k++; end
        checks++;
        if (launches.size() == n) begin
            failures++; $display("FAIL handshake_timeout got=no_launch exp=launch");
        end
        tb_busy = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL rst_flags got=e%b f%b exp=e1 f0", empty, full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        checks++; if (start_trigger !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL rst_out got=%b/%h exp=0/00", start_trigger, tx_data); end
    endtask

    task automatic test_latency();
        int p;
        do_reset();
        push_byte(8'hA5);
        p = cyc;
        checks++; if (start_trigger !== 1'b0 || count !== 5'd1) begin failures++; $display("FAIL lat_push got=st%b cnt%0d exp=st0 cnt1", start_trigger, count); end
        step();
        checks++; if (start_trigger !== 1'b1 || tx_data !== 8'hA5) begin failures++; $display("FAIL lat_launch got=st%b %h exp=st1 a5", start_trigger, tx_data); end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL lat_count got=%0d e%b exp=0 e1", count, empty); end
        checks++; if (launch_cyc[launch_cyc.size()-1] !== p + 1) begin failures++; $display("FAIL lat_cycle got=%0d exp=%0d", launch_cyc[launch_cyc.size()-1], p + 1); end
        step();
        checks++; if (start_trigger !== 1'b0 || tx_data !== 8'hA5) begin failures++; $display("FAIL lat_hold got=st%b %h exp=st0 a5", start_trigger, tx_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[3] = '{8'h55, 8'hAA, 8'h0F};
        int b, fb, p, k;
        do_reset();
        busy_min = 160; busy_max = 160; tx_auto = 1'b1;
        b = launches.size(); fb = fall_cyc.size();
        push_byte(exp[0]); p = cyc;
        push_byte(exp[1]);
        push_byte(exp[2]);
        k = 0;
        while (fall_cyc.size() < fb + 3 && k < 800) begin step(); k++; end
        checks++;
        if (fall_cyc.size() < fb + 3 || launches.size() != b + 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", launches.size() - b);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (launches[b+i] !== exp[i]) begin failures++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, launches[b+i], exp[i]); end
            end
            checks++; if (launch_cyc[b] !== p + 1) begin failures++; $display("FAIL b2b_first got=%0d exp=%0d", launch_cyc[b], p + 1); end
            // busy falls after edge f; FSM samples it low at f+1 and launches at f+2
            for (int i = 1; i < 3; i++) begin
                checks++; if (launch_cyc[b+i] !== fall_cyc[fb+i-1] + 2) begin failures++; $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", i, launch_cyc[b+i], fall_cyc[fb+i-1] + 2); end
            end
        end
        tx_auto = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        tb_busy = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            push_byte(8'(i));
            if (i == 15) begin
                checks++; if (full !== 1'b0 || count !== 5'd15) begin failures++; $display("FAIL ovf_15 got=f%b %0d exp=f0 15", full, count); end
            end
            if (i == 16) begin
                checks++; if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_16 got=f%b %0d o%b exp=f1 16 o0", full, count, overflow); end
            end
        end
        checks++; if (overflow !== 1'b1 || count !== 5'd16) begin failures++; $display("FAIL ovf_17 got=o%b %0d exp=o1 16", overflow, count); end
        clr_ovf = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        step();
        clr_ovf = 1'b0; wr_en = 1'b0;
        checks++; if (overflow !== 1'b0 || count !== 5'd16) begin failures++; $display("FAIL ovf_clr_wins got=o%b %0d exp=o0 16", overflow, count); end
    endtask

    task automatic test_wrap_same_cycle();
        logic [7:0] bytes[17];
        int b;
        do_reset();
        for (int i = 0; i < 17; i++) bytes[i] = 8'($urandom);
        b = launches.size();
        tb_busy = 1'b1;
        for (int i = 0; i < 15; i++) push_byte(bytes[i]);
        for (int i = 0; i < 12; i++) handshake();
        checks++; if (count !== 5'd3) begin failures++; $display("FAIL wrap_pre got=%0d exp=3", count); end
        tb_busy = 1'b0;
        step();
        wr_en = 1'b1; wr_data = bytes[15];
        step();
        checks++; if (start_trigger !== 1'b1 || tx_data !== bytes[12] || count !== 5'd3) begin failures++; $display("FAIL wrap_same got=st%b %h %0d exp=st1 %h 3", start_trigger, tx_data, count, bytes[12]); end
        wr_data = bytes[16]; tb_busy = 1'b1;
        step();
        wr_en = 1'b0;
        checks++; if (count !== 5'd4) begin failures++; $display("FAIL wrap_post got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) handshake();
        checks++;
        if (launches.size() != b + 17) begin
            failures++; $display("FAIL wrap_count got=%0d exp=17", launches.size() - b);
        end else begin
            for (int i = 0; i < 17; i++) begin
                checks++; if (launches[b+i] !== bytes[i]) begin failures++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, launches[b+i], bytes[i]); end
            end
        end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL wrap_end got=%0d e%b exp=0 e1", count, empty); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        do_reset();
        tb_busy = 1'b1;
        for (int i = 0; i < 17; i++) push_byte(8'(8'h30 + i));
        for (int i = 0; i < 11; i++) handshake();
        checks++; if (count !== 5'd5 || overflow !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d o%b exp=5 o1", count, overflow); end
        rst = 1'b0;
        #1;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL mid_async_cnt got=%0d e%b f%b exp=0 e1 f0", count, empty, full); end
        checks++; if (overflow !== 1'b0 || start_trigger !== 1'b0 || tx_data !== 8'h00) begin failures++; $display("FAIL mid_async_out got=o%b st%b %h exp=o0 st0 00", overflow, start_trigger, tx_data); end
        step();
        rst = 1'b1; tb_busy = 1'b0;
        n = launches.size();
        repeat (6) step();
        checks++; if (launches.size() !== n) begin failures++; $display("FAIL mid_no_launch got=%0d exp=0", launches.size() - n); end
    endtask

`ifdef UART_TXQ_FLUSH_EN
    task automatic test_flush();
        int n;
        do_reset();
        tb_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i));
        n = launches.size();
        handshake();
        checks++; if (launches.size() != n + 1 || launches[n] !== 8'hC0) begin failures++; $display("FAIL flush_first got=%0d exp=1", launches.size() - n); end
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        step();
        flush = 1'b0; wr_en = 1'b0;
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL flush_count got=%0d e%b exp=0 e1", count, empty); end
        tb_busy = 1'b0;
        repeat (10) step();
        checks++; if (launches.size() !== n + 1) begin failures++; $display("FAIL flush_no_launch got=%0d exp=1", launches.size() - n); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] exp_q[$];
        int mcount = 0;
        bit exp_ovf = 1'b0;
        int b, n, pre, k, bad;
        bit att, acc;
        do_reset();
        busy_min = 1; busy_max = 6; tx_auto = 1'b1;
        b = launches.size();
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            wr_en   = ($urandom_range(99) < 70);
            wr_data = 8'($urandom);
            clr_ovf = ($urandom_range(99) < 5);
            pre = mcount; att = wr_en;
            acc = att && (pre < DEPTH);
            if (acc) exp_q.push_back(wr_data);
            if (clr_ovf) exp_ovf = 1'b0;
            else if (att && pre == DEPTH) exp_ovf = 1'b1;
            n = launches.size();
            step();
            mcount = pre + int'(acc) - (launches.size() - n);
            checks++;
            if (count !== (AW+1)'(mcount) || full !== (mcount == DEPTH) || empty !== (mcount == 0) || overflow !== exp_ovf) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL rnd_state c=%0d got=%0d f%b e%b o%b exp=%0d o%b", c, count, full, empty, overflow, mcount, exp_ovf);
            end
        end
        wr_en = 1'b0; clr_ovf = 1'b0;
        k = 0;
        while (launches.size() - b < exp_q.size() && k < 3000) begin step(); k++; end
        repeat (20) step();
        checks++;
        if (launches.size() - b != exp_q.size()) begin
            failures++; $display("FAIL rnd_count got=%0d exp=%0d", launches.size() - b, exp_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (launches[b+i] !== exp_q[i]) begin
                    failures++; bad++;
                    if (bad < 5) $display("FAIL rnd_order[%0d] got=%h exp=%h", i, launches[b+i], exp_q[i]);
                end
            end
        end
        checks++; if (dbl_pulse !== 0) begin failures++; $display("FAIL rnd_pulse_width got=%0d exp=0", dbl_pulse); end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL rnd_drain got=%0d e%b exp=0 e1", count, empty); end
        tx_auto = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_overflow();
        test_wrap_same_cycle();
        test_reset_mid_frame();
`ifdef UART_TXQ_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
